// File: rtl/ysyx_23060303_pkg.sv
// Shared write-back definitions: source ids, default widths, zero register.
package ysyx_23060303_pkg;

  localparam int ADDR_WIDTH_DEF = 5;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int REG_ZERO       = 0;

  typedef enum logic {
    SRC_EXU = 1'b0,
    SRC_LSU = 1'b1
  } src_e;

endpackage

// File: rtl/ysyx_23060303_scoreboard.sv
// Pending-write vector: set on issue, cleared on commit, busy lookup is a plain registered bit.
// Latency: issue visible as busy next cycle; commit clears on the write edge; no backpressure.
module ysyx_23060303_scoreboard
  import ysyx_23060303_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  iss_valid,
  input  logic [ADDR_WIDTH-1:0] iss_rd,
  input  logic                  clr_valid,
  input  logic [ADDR_WIDTH-1:0] clr_rd,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  output logic                  rs1_busy,
  output logic                  rs2_busy
);

  localparam int NREG = 2 ** ADDR_WIDTH;

  logic [NREG-1:0] pending;
  logic [NREG-1:0] pending_nxt;

  // Set is applied after clear so a new producer wins over the retiring one.
  always_comb begin
    pending_nxt = pending;
    if (clr_valid) pending_nxt[clr_rd] = 1'b0;
    if (iss_valid && iss_rd != ADDR_WIDTH'(REG_ZERO)) pending_nxt[iss_rd] = 1'b1;
    pending_nxt[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= pending_nxt;
  end

  assign rs1_busy = pending[rs1];
  assign rs2_busy = pending[rs2];

endmodule

// File: rtl/ysyx_23060303_wb_arbiter.sv
// Round-robin EXU/LSU write-back arbiter with a registered one-cycle RF write strobe; never back-pressures downstream.
// Ready is combinational with valid; write lands one cycle after handshake. Scoreboard built under YSYX_23060303_SCOREBOARD_EN.
module ysyx_23060303_wb_arbiter
  import ysyx_23060303_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  exu_valid,
  output logic                  exu_ready,
  input  logic [ADDR_WIDTH-1:0] exu_waddr,
  input  logic [DATA_WIDTH-1:0] exu_wdata,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_waddr,
  input  logic [DATA_WIDTH-1:0] lsu_wdata,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  input  logic                  iss_valid,
  input  logic [ADDR_WIDTH-1:0] iss_rd,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  output logic                  rs1_busy,
  output logic                  rs2_busy
);

  src_e                  last_grant;
  logic                  grant_lsu;
  logic                  hs;
  logic [ADDR_WIDTH-1:0] sel_waddr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  // On a tie the source that did not win last time gets the port.
  always_comb begin
    grant_lsu = lsu_valid && (!exu_valid || last_grant == SRC_EXU);
    exu_ready = exu_valid && !grant_lsu;
    lsu_ready = grant_lsu;
    hs        = exu_valid || lsu_valid;
    sel_waddr = grant_lsu ? lsu_waddr : exu_waddr;
    sel_wdata = grant_lsu ? lsu_wdata : exu_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= SRC_EXU;
      rf_wen     <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
    end else begin
      rf_wen <= 1'b0;
      if (hs) begin
        last_grant <= grant_lsu ? SRC_LSU : SRC_EXU;
        rf_wen     <= (sel_waddr != ADDR_WIDTH'(REG_ZERO));
        rf_waddr   <= sel_waddr;
        rf_wdata   <= sel_wdata;
      end
    end
  end

`ifdef YSYX_23060303_SCOREBOARD_EN
  ysyx_23060303_scoreboard #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .iss_valid(iss_valid),
    .iss_rd   (iss_rd),
    .clr_valid(rf_wen),
    .clr_rd   (rf_waddr),
    .rs1      (rs1),
    .rs2      (rs2),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy)
  );
`else
  logic unused_sb;
  assign unused_sb = ^{iss_valid, iss_rd, rs1, rs2};
  assign rs1_busy  = 1'b0;
  assign rs2_busy  = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_23060303_wb_arbiter.sv
// Bench for the write-back arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_ysyx_23060303_wb_arbiter;

`ifdef YSYX_23060303_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        exu_valid = 1'b0, lsu_valid = 1'b0, iss_valid = 1'b0;
  logic        exu_ready, lsu_ready, rf_wen, rs1_busy, rs2_busy;
  logic [4:0]  exu_waddr = '0, lsu_waddr = '0, iss_rd = '0, rs1 = '0, rs2 = '0, rf_waddr;
  logic [31:0] exu_wdata = '0, lsu_wdata = '0, rf_wdata;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model state: who won last, the pending write, and in-flight destinations.
  bit          m_last = 1'b0;
  bit          m_wen = 1'b0;
  logic [4:0]  m_waddr = '0;
  logic [31:0] m_wdata = '0;
  bit [31:0]   m_pend = '0;

  ysyx_23060303_wb_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_waddr(exu_waddr), .exu_wdata(exu_wdata),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_waddr(lsu_waddr), .lsu_wdata(lsu_wdata),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .rs1(rs1), .rs2(rs2),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy)
  );

  always #5 clk = ~clk;

  function automatic bit model_lsu();
    return lsu_valid && (!exu_valid || !m_last);
  endfunction

  task automatic model_reset();
    m_last = 1'b0; m_wen = 1'b0; m_waddr = '0; m_wdata = '0; m_pend = '0;
  endtask

  // Advance one clock (from a negedge to the next) and step the model across the rising edge.
  task automatic tick();
    bit          gl, any, iv;
    logic [4:0]  ia, ga;
    logic [31:0] gd;
    gl = model_lsu();
    any = exu_valid || lsu_valid;
    iv = iss_valid;
    ia = iss_rd;
    ga = gl ? lsu_waddr : exu_waddr;
    gd = gl ? lsu_wdata : exu_wdata;
    assert (!(iv && ia != 0 && m_pend[ia] && !(m_wen && m_waddr == ia)))
      else $error("issue to an already pending rd %0d", ia);
    @(posedge clk);
    if (m_wen) m_pend[m_waddr] = 1'b0;
    if (iv && ia != 0) m_pend[ia] = 1'b1;
    if (any) begin
      m_last = gl; m_wen = (ga != 0); m_waddr = ga; m_wdata = gd;
    end else begin
      m_wen = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    exu_valid = 1'b0; lsu_valid = 1'b0; iss_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    #1;
    n_cmp++; if (rf_wen !== 1'b0) begin n_fail++; $display("FAIL reset_wen: got %b want 0", rf_wen); end
    n_cmp++; if (rf_waddr !== 5'd0) begin n_fail++; $display("FAIL reset_waddr: got %0d want 0", rf_waddr); end
    n_cmp++; if (rf_wdata !== 32'd0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", rf_wdata); end
    n_cmp++; if ({exu_ready, lsu_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b want 00", {exu_ready, lsu_ready}); end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_exu_single();
    exu_valid = 1'b1; exu_waddr = 5'd5; exu_wdata = 32'h1234;
    #1;
    n_cmp++; if ({exu_ready, lsu_ready} !== 2'b10) begin n_fail++; $display("FAIL exu_ready: got %b want 10", {exu_ready, lsu_ready}); end
    tick();
    exu_valid = 1'b0;
    n_cmp++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h1234) begin
      n_fail++; $display("FAIL exu_write: got wen=%b addr=%0d data=%h want 1/5/1234", rf_wen, rf_waddr, rf_wdata);
    end
    tick();
    n_cmp++; if (rf_wen !== 1'b0) begin n_fail++; $display("FAIL exu_strobe_len: got %b want 0", rf_wen); end
  endtask

  task automatic test_round_robin();
    int ei = 0, li = 0;
    logic [31:0] ed, ld;
    ed = $urandom; ld = $urandom;
    for (int c = 0; c < 4; c++) begin
      bit exp_l;
      logic [4:0]  xa;
      logic [31:0] xd;
      exp_l = (c % 2 == 0);
      exu_valid = 1'b1; exu_waddr = 5'(1 + ei); exu_wdata = ed;
      lsu_valid = 1'b1; lsu_waddr = 5'(9 + li); lsu_wdata = ld;
      #1;
      n_cmp++; if ({exu_ready, lsu_ready} !== {!exp_l, exp_l}) begin
        n_fail++; $display("FAIL rr_grant[%0d]: got e=%b l=%b want lsu=%b", c, exu_ready, lsu_ready, exp_l);
      end
      xa = exp_l ? lsu_waddr : exu_waddr;
      xd = exp_l ? ld : ed;
      tick();
      n_cmp++; if (rf_wen !== 1'b1 || rf_waddr !== xa || rf_wdata !== xd) begin
        n_fail++; $display("FAIL rr_write[%0d]: got %b/%0d/%h want 1/%0d/%h", c, rf_wen, rf_waddr, rf_wdata, xa, xd);
      end
      if (exp_l) begin li++; ld = $urandom; end
      else begin ei++; ed = $urandom; end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_x0();
    lsu_valid = 1'b1; lsu_waddr = 5'd0; lsu_wdata = 32'hDEAD;
    #1;
    n_cmp++; if (lsu_ready !== 1'b1) begin n_fail++; $display("FAIL x0_ready: got %b want 1", lsu_ready); end
    tick();
    lsu_valid = 1'b0;
    n_cmp++; if (rf_wen !== 1'b0) begin n_fail++; $display("FAIL x0_wen: got %b want 0", rf_wen); end
  endtask

  task automatic test_scoreboard();
    iss_valid = 1'b1; iss_rd = 5'd7; rs1 = 5'd7;
    tick();
    iss_valid = 1'b0;
    #1;
    n_cmp++; if (rs1_busy !== SB) begin n_fail++; $display("FAIL sb_set: got %b want %b", rs1_busy, SB); end
    tick(); tick();
    lsu_valid = 1'b1; lsu_waddr = 5'd7; lsu_wdata = 32'hCAFE0007;
    #1;
    n_cmp++; if (rs1_busy !== SB) begin n_fail++; $display("FAIL sb_hold: got %b want %b", rs1_busy, SB); end
    tick();
    lsu_valid = 1'b0;
    #1;
    n_cmp++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd7 || rs1_busy !== SB) begin
      n_fail++; $display("FAIL sb_commit: got wen=%b addr=%0d busy=%b want 1/7/%b", rf_wen, rf_waddr, rs1_busy, SB);
    end
    tick();
    #1;
    n_cmp++; if (rs1_busy !== 1'b0) begin n_fail++; $display("FAIL sb_clear: got %b want 0", rs1_busy); end
    // Issue and write-back to 7 together, then re-issue 7 on the commit edge.
    iss_valid = 1'b1; iss_rd = 5'd7; lsu_valid = 1'b1; lsu_waddr = 5'd7; lsu_wdata = 32'h77;
    tick();
    lsu_valid = 1'b0;
    tick();
    iss_valid = 1'b0;
    #1;
    n_cmp++; if (rs1_busy !== SB) begin n_fail++; $display("FAIL sb_set_wins: got %b want %b", rs1_busy, SB); end
    exu_valid = 1'b1; exu_waddr = 5'd7; exu_wdata = 32'h70;
    tick();
    exu_valid = 1'b0;
    tick();
    #1;
    n_cmp++; if (rs1_busy !== 1'b0) begin n_fail++; $display("FAIL sb_final_clear: got %b want 0", rs1_busy); end
  endtask

  task automatic test_reset_mid();
    iss_valid = 1'b1; iss_rd = 5'd3; rs1 = 5'd3;
    lsu_valid = 1'b1; lsu_waddr = 5'd3; lsu_wdata = 32'h33;
    tick();
    idle_inputs();
    #1;
    n_cmp++; if (rf_wen !== 1'b1 || rs1_busy !== SB) begin
      n_fail++; $display("FAIL rst_pre: got wen=%b busy=%b want 1/%b", rf_wen, rs1_busy, SB);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (rf_wen !== 1'b0 || rs1_busy !== 1'b0 || rf_waddr !== 5'd0) begin
      n_fail++; $display("FAIL rst_async: got wen=%b busy=%b addr=%0d want 0/0/0", rf_wen, rs1_busy, rf_waddr);
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    bit e_hold = 1'b0, l_hold = 1'b0;
    for (int c = 0; c < 400; c++) begin
      bit exp_l, exp_e;
      logic [4:0] rd;
      if (!e_hold) begin exu_valid = 1'($urandom); exu_waddr = 5'($urandom); exu_wdata = $urandom; end
      if (!l_hold) begin lsu_valid = 1'($urandom); lsu_waddr = 5'($urandom); lsu_wdata = $urandom; end
      rd = 5'($urandom);
      iss_valid = ($urandom_range(0, 2) == 0) && rd != 0 && !m_pend[rd];
      iss_rd = rd;
      rs1 = 5'($urandom); rs2 = 5'($urandom);
      #1;
      exp_l = model_lsu();
      exp_e = exu_valid && !exp_l;
      n_cmp++; if ({exu_ready, lsu_ready} !== {exp_e, exp_l}) begin
        n_fail++; $display("FAIL rnd_ready[%0d]: got %b%b want %b%b", c, exu_ready, lsu_ready, exp_e, exp_l);
      end
      n_cmp++; if ({rs1_busy, rs2_busy} !== {SB & m_pend[rs1], SB & m_pend[rs2]}) begin
        n_fail++; $display("FAIL rnd_busy[%0d]: got %b%b want %b%b", c, rs1_busy, rs2_busy, SB & m_pend[rs1], SB & m_pend[rs2]);
      end
      e_hold = exu_valid && !exp_e;
      l_hold = lsu_valid && !exp_l;
      tick();
      n_cmp++; if (rf_wen !== m_wen) begin n_fail++; $display("FAIL rnd_wen[%0d]: got %b want %b", c, rf_wen, m_wen); end
      if (m_wen) begin
        n_cmp++; if (rf_waddr !== m_waddr || rf_wdata !== m_wdata) begin
          n_fail++; $display("FAIL rnd_wdata[%0d]: got %0d/%h want %0d/%h", c, rf_waddr, rf_wdata, m_waddr, m_wdata);
        end
      end
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_exu_single();
    test_round_robin();
    test_x0();
    test_scoreboard();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
